// File: rtl/floo_tb_clint_pkg.sv
// ============================================================================
// floo_tb_clint_pkg
// Register map, request/response bundles and FSM encoding for the harness CLINT.
// Revision: 1.0
// ============================================================================
`default_nettype none

package floo_tb_clint_pkg;

    localparam logic [15:0] MsipBase     = 16'h0000;
    localparam logic [15:0] MtimeCmpBase = 16'h4000;
    localparam logic [15:0] MtimeBase    = 16'hBFF8;
    localparam logic [15:0] EocAddr      = 16'hC000;

    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StResp = 1'b1
    } state_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/floo_tb_clint_timer.sv
// ============================================================================
// floo_tb_clint_timer
// Prescaler and 64-bit mtime with a byte-strobed 32-bit half-word write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module floo_tb_clint_timer
    import floo_tb_clint_pkg::*;
#(
    parameter int unsigned Prescale = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  strb_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned     CntW   = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Prescale - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     mtime_q, mtime_d;
    logic            tick;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    // A software write wins over the tick; the other half keeps its old value.
    always_comb begin
        mtime_d = mtime_q;
        if (we_lo_i || we_hi_i) begin
            if (we_lo_i) mtime_d[31:0]  = strb_merge(mtime_q[31:0], wdata_i, strb_i);
            if (we_hi_i) mtime_d[63:32] = strb_merge(mtime_q[63:32], wdata_i, strb_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            mtime_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

`default_nettype wire

// File: rtl/floo_tb_clint_regs.sv
// ============================================================================
// floo_tb_clint_regs
// CLINT register block: decode, single-outstanding request FSM, msip/mtimecmp/EOC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module floo_tb_clint_regs
    import floo_tb_clint_pkg::*;
#(
    parameter int unsigned NumCores    = 16,
    parameter int unsigned AddrWidth   = 16,
    parameter int unsigned Prescale    = 1,
    parameter logic [63:0] MtimeCmpRst = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_strb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NumCores-1:0]  msip_o,
    output logic [NumCores-1:0]  mtip_o,
    output logic                 eoc_valid_o,
    output logic [31:0]          eoc_code_o
);

    localparam int unsigned IdxW    = (NumCores > 1) ? $clog2(NumCores) : 1;
    localparam int unsigned MsipEnd = 32'(MsipBase) + 4 * NumCores;
    localparam int unsigned CmpEnd  = 32'(MtimeCmpBase) + 8 * NumCores;

    state_e        state_q, state_d;
    reg_req_t      w_req;
    reg_rsp_t      w_rsp, rsp_q;
    logic          w_acc, w_wr, w_upper_zero;
    logic [15:0]   w_addr;
    logic          w_hit_msip, w_hit_cmp, w_hit_mtlo, w_hit_mthi, w_hit_eoc;
    logic [IdxW-1:0] w_msip_idx, w_cmp_idx;
    logic [63:0]   w_mtime;
    logic [63:0]   w_cmp [NumCores];
    logic          eoc_valid_q;
    logic [31:0]   eoc_code_q;

    if (AddrWidth > 16) begin : g_addr_upper
        assign w_upper_zero = (req_addr_i[AddrWidth-1:16] == '0);
    end else begin : g_addr_exact
        assign w_upper_zero = 1'b1;
    end

    assign w_req  = '{write: req_write_i, wdata: req_wdata_i, strb: req_strb_i};
    assign w_addr = req_addr_i[15:0] & 16'hFFFC;

    always_comb begin
        w_hit_msip = w_upper_zero && (32'(w_addr) >= 32'(MsipBase)) && (32'(w_addr) < MsipEnd);
        w_hit_cmp  = w_upper_zero && (32'(w_addr) >= 32'(MtimeCmpBase)) && (32'(w_addr) < CmpEnd);
        w_hit_mtlo = w_upper_zero && (w_addr == MtimeBase);
        w_hit_mthi = w_upper_zero && (w_addr == MtimeBase + 16'd4);
        w_hit_eoc  = w_upper_zero && (w_addr == EocAddr);
        w_msip_idx = IdxW'((w_addr - MsipBase) >> 2);
        w_cmp_idx  = IdxW'((w_addr - MtimeCmpBase) >> 3);
    end

    assign w_acc = req_valid_i && (state_q == StIdle);
    assign w_wr  = w_acc && w_req.write && (w_req.strb != 4'h0);

    // Read data is captured at acceptance; writes and errors answer with zero.
    always_comb begin
        w_rsp = '0;
        if (w_hit_msip) begin
            w_rsp.rdata = {31'b0, msip_o[w_msip_idx]};
        end else if (w_hit_cmp) begin
            w_rsp.rdata = w_addr[2] ? w_cmp[w_cmp_idx][63:32] : w_cmp[w_cmp_idx][31:0];
        end else if (w_hit_mtlo) begin
            w_rsp.rdata = w_mtime[31:0];
        end else if (w_hit_mthi) begin
            w_rsp.rdata = w_mtime[63:32];
        end else if (w_hit_eoc) begin
            w_rsp.rdata = eoc_code_q;
        end else begin
            w_rsp.error = 1'b1;
        end
        if (w_req.write || w_rsp.error) w_rsp.rdata = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (req_valid_i) state_d = StResp;
            StResp: if (rsp_ready_i) state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
        rsp_rdata_o = rsp_q.rdata;
        rsp_error_o = rsp_q.error;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_q <= '0;
        else if (w_acc) rsp_q <= w_rsp;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eoc_valid_q <= 1'b0;
            eoc_code_q  <= '0;
        end else if (w_wr && w_hit_eoc && ((w_req.wdata & strb_mask(w_req.strb)) != '0)) begin
            eoc_valid_q <= 1'b1;
            eoc_code_q  <= strb_merge(eoc_code_q, w_req.wdata, w_req.strb);
        end
    end

    assign eoc_valid_o = eoc_valid_q;
    assign eoc_code_o  = eoc_code_q;

    for (genvar i = 0; i < NumCores; i++) begin : g_core
        logic        msip_q;
        logic        mtip_q;
        logic [63:0] mtimecmp_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                msip_q     <= 1'b0;
                mtip_q     <= 1'b0;
                mtimecmp_q <= MtimeCmpRst;
            end else begin
                if (w_wr && w_hit_msip && (w_msip_idx == IdxW'(i)) && w_req.strb[0]) begin
                    msip_q <= w_req.wdata[0];
                end
                if (w_wr && w_hit_cmp && (w_cmp_idx == IdxW'(i))) begin
                    if (w_addr[2]) mtimecmp_q[63:32] <= strb_merge(mtimecmp_q[63:32], w_req.wdata, w_req.strb);
                    else           mtimecmp_q[31:0]  <= strb_merge(mtimecmp_q[31:0], w_req.wdata, w_req.strb);
                end
                mtip_q <= (w_mtime >= mtimecmp_q);
            end
        end

        assign msip_o[i] = msip_q;
        assign mtip_o[i] = mtip_q;
        assign w_cmp[i]  = mtimecmp_q;
    end

    floo_tb_clint_timer #(
        .Prescale (Prescale)
    ) i_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_lo_i (w_wr && w_hit_mtlo),
        .we_hi_i (w_wr && w_hit_mthi),
        .wdata_i (w_req.wdata),
        .strb_i  (w_req.strb),
        .mtime_o (w_mtime)
    );

endmodule

`default_nettype wire

// File: tb/tb_floo_tb_clint_regs.sv
// ============================================================================
// tb_floo_tb_clint_regs
// Directed and randomized register traffic against a behavioural CLINT model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_floo_tb_clint_regs;

    localparam int unsigned NC = 8;
    localparam int unsigned P  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic [15:0]   req_addr = '0;
    logic          req_write = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_strb = '0;
    logic          rsp_valid_o;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_error_o;
    logic [NC-1:0] msip_o, mtip_o;
    logic          eoc_valid_o;
    logic [31:0]   eoc_code_o;

    always #5 clk = ~clk;

    floo_tb_clint_regs #(
        .NumCores    (NC),
        .AddrWidth   (16),
        .Prescale    (P),
        .MtimeCmpRst ('1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .msip_o      (msip_o),
        .mtip_o      (mtip_o),
        .eoc_valid_o (eoc_valid_o),
        .eoc_code_o  (eoc_code_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Rising edges since reset release; mtime ticks on every P-th edge.
    int unsigned ecnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    logic [NC-1:0] msip_m;
    logic [63:0]   cmp_m [NC];
    logic [63:0]   mt_base;
    int unsigned   mt_edge;
    logic          eoc_v_m;
    logic [31:0]   eoc_c_m;
    logic [31:0]   rd;
    logic          er;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mt_at(input int unsigned e);
        return mt_base + 64'(e / P) - 64'(mt_edge / P);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] st);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (st[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    // Apply one accepted access at edge w to the model; return the expected response.
    task automatic model_access(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                                input logic [3:0] st, input int unsigned w,
                                output logic [31:0] erd, output logic eer);
        int unsigned a, i;
        logic [31:0] m, old;
        logic [63:0] pre;
        a   = 32'(addr) & 32'hFFFC;
        m   = bmask(st);
        erd = '0;
        eer = 1'b0;
        if (a < 4 * NC) begin
            i = a / 4;
            if (!wr) erd = {31'b0, msip_m[i]};
            else if (st[0]) msip_m[i] = wd[0];
        end else if (a >= 32'h4000 && a < 32'h4000 + 8 * NC) begin
            i = (a - 32'h4000) / 8;
            if ((a % 8) != 0) begin
                old = cmp_m[i][63:32];
                if (!wr) erd = old;
                else cmp_m[i][63:32] = (old & ~m) | (wd & m);
            end else begin
                old = cmp_m[i][31:0];
                if (!wr) erd = old;
                else cmp_m[i][31:0] = (old & ~m) | (wd & m);
            end
        end else if (a == 32'hBFF8 || a == 32'hBFFC) begin
            pre = mt_at(w - 1);
            if (!wr) begin
                erd = (a == 32'hBFFC) ? pre[63:32] : pre[31:0];
            end else if (st != 4'h0) begin
                if (a == 32'hBFFC) pre[63:32] = (pre[63:32] & ~m) | (wd & m);
                else               pre[31:0]  = (pre[31:0] & ~m) | (wd & m);
                mt_base = pre;
                mt_edge = w;
            end
        end else if (a == 32'hC000) begin
            if (!wr) erd = eoc_c_m;
            else if ((wd & m) != 0) begin
                eoc_c_m = (eoc_c_m & ~m) | (wd & m);
                eoc_v_m = 1'b1;
            end
        end else begin
            eoc_v_m = eoc_v_m;
            eer     = 1'b1;
        end
    endtask

    task automatic do_txn(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] ord, output logic oer);
        int unsigned w;
        int guard;
        logic [31:0] erd;
        logic eer;
        logic [NC-1:0] emtip;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_strb  = st;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) chk("req_ready_timeout", req_ready_o, 1'b1);
        @(posedge clk);
        #1;
        w = ecnt;
        model_access(addr, wr, wd, st, w, erd, eer);
        @(negedge clk);
        req_valid = 1'b0;
        ord = rsp_rdata_o;
        oer = rsp_error_o;
        chk("rsp_valid", rsp_valid_o, 1'b1);
        chk("rsp_rdata", ord, erd);
        chk("rsp_error", oer, eer);
        chk("req_ready_busy", req_ready_o, 1'b0);
        chk("msip", msip_o, msip_m);
        chk("eoc_valid", eoc_valid_o, eoc_v_m);
        chk("eoc_code", eoc_code_o, eoc_c_m);
        @(negedge clk);
        chk("rsp_valid_after_hs", rsp_valid_o, 1'b0);
        for (int i = 0; i < NC; i++) emtip[i] = (mt_at(w) >= cmp_m[i]);
        chk("mtip", mtip_o, emtip);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int unsigned kind;
        logic [15:0] a;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  st;

        msip_m  = '0;
        for (int i = 0; i < NC; i++) cmp_m[i] = '1;
        mt_base = '0;
        mt_edge = 0;
        eoc_v_m = 1'b0;
        eoc_c_m = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_rsp_error", rsp_error_o, 1'b0);
        chk("rst_msip", msip_o, '0);
        chk("rst_mtip", mtip_o, '0);
        chk("rst_eoc_valid", eoc_valid_o, 1'b0);
        chk("rst_eoc_code", eoc_code_o, 32'h0);

        do_txn(16'h4000, 1'b0, '0, 4'h0, rd, er);
        chk("cmp0_lo_rst", rd, 32'hFFFF_FFFF);
        do_txn(16'h4004, 1'b0, '0, 4'h0, rd, er);
        chk("cmp0_hi_rst", rd, 32'hFFFF_FFFF);

        do_txn(16'h0008, 1'b1, 32'h1, 4'hF, rd, er);
        chk("msip_core2_set", msip_o, 8'h04);
        do_txn(16'h0008, 1'b1, 32'h0, 4'hF, rd, er);
        chk("msip_core2_clr", msip_o, 8'h00);

        do_txn(16'h4000, 1'b1, 32'd10, 4'hF, rd, er);
        do_txn(16'h4004, 1'b1, 32'd0, 4'hF, rd, er);
        rise = 0;
        for (int k = 0; k < 100 && rise == 0; k++) begin
            @(negedge clk);
            if (mtip_o[0]) rise = int'(ecnt);
        end
        chk("mtip0_rise_window", (rise >= 41 && rise <= 42), 1'b1);
        do_txn(16'hBFF8, 1'b0, '0, 4'h0, rd, er);
        chk("mtime_at_rise", (rd >= 10 && rd <= 11), 1'b1);

        do_txn(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er);
        do_txn(16'hBFF8, 1'b1, 32'hFFFF_FFFE, 4'hF, rd, er);
        repeat (8) @(negedge clk);
        do_txn(16'hBFFC, 1'b0, '0, 4'h0, rd, er);
        chk("mtime_wrap_hi", rd, 32'h0);
        chk("mtime_wrap_err", er, 1'b0);
        do_txn(16'hBFF8, 1'b0, '0, 4'h0, rd, er);

        @(negedge clk);
        chk("stall_idle_ready", req_ready_o, 1'b1);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'h8000;
        req_write = 1'b0;
        req_wdata = '0;
        req_strb  = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_valid", rsp_valid_o, 1'b1);
            chk("stall_rsp_error", rsp_error_o, 1'b1);
            chk("stall_rsp_rdata", rsp_rdata_o, 32'h0);
            chk("stall_req_ready", req_ready_o, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", rsp_valid_o, 1'b0);

        do_txn(16'hC000, 1'b1, 32'h0, 4'hF, rd, er);
        chk("eoc_zero_ignored", eoc_valid_o, 1'b0);
        do_txn(16'hC000, 1'b1, 32'h2A, 4'hF, rd, er);
        chk("eoc_valid_set", eoc_valid_o, 1'b1);
        chk("eoc_code_2a", eoc_code_o, 32'h2A);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            st   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (kind)
                0, 1: begin
                    a  = 16'(4 * $urandom_range(0, NC));
                    wd = 32'($urandom_range(0, 3));
                end
                2, 3, 4: begin
                    a = 16'h4000 + 16'(8 * $urandom_range(0, NC)) + 16'(4 * $urandom_range(0, 1));
                    if ($urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 300));
                end
                5: begin
                    a  = ($urandom_range(0, 1) == 1) ? 16'hBFFC : 16'hBFF8;
                    wd = (a == 16'hBFFC) ? 32'h0 : 32'($urandom_range(0, 400));
                end
                6: begin
                    a  = 16'hC000;
                    wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                end
                7: a = 16'($urandom);
                default: begin
                    a  = ($urandom_range(0, 1) == 1) ? 16'hBFF8 : 16'hBFFC;
                    wr = 1'b0;
                end
            endcase
            a = a | 16'($urandom_range(0, 3));
            do_txn(a, wr, wd, st, rd, er);
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'hC000;
        req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_reset_rsp_valid", rsp_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rsp_valid", rsp_valid_o, 1'b0);
        chk("mid_reset_req_ready", req_ready_o, 1'b1);
        chk("mid_reset_rdata", rsp_rdata_o, 32'h0);
        chk("mid_reset_eoc_valid", eoc_valid_o, 1'b0);
        chk("mid_reset_msip", msip_o, '0);
        chk("mid_reset_mtip", mtip_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
